// File: rtl/multicycle_controller.sv
// Multicycle control FSM: fetch handshake, program counter, decode and EXEC/WB control sequencing.
// Optional retired-instruction counter enabled by defining MULTICYCLE_CTRL_RETIRE_CNT_EN.
module multicycle_controller #(
  parameter logic [15:0] RESET_PC      = 16'h0000,
  parameter logic [15:0] PC_STEP       = 16'd1,
  parameter int unsigned FETCH_TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        run,
  input  logic        imem_ack,
  input  logic [3:0]  Op,
  input  logic        a_zero,
  input  logic [15:0] ALUOut,
  output logic        imem_req,
  output logic [15:0] PC,
  output logic        IRWrite,
  output logic [2:0]  ALUOp,
  output logic        ALUSrcA,
  output logic        ALUSrcB,
  output logic [1:0]  immShift,
  output logic [1:0]  numBits,
  output logic        writeEnable,
  output logic        busy,
  output logic        halted,
  output logic        fault
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
  ,
  output logic [15:0] retired
`endif
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;
  localparam logic [2:0] S_FAULT  = 3'd6;

  localparam logic [3:0] OP_LUI  = 4'hC;
  localparam logic [3:0] OP_BRZ  = 4'hD;
  localparam logic [3:0] OP_NOP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Last wait cycle allowed before the fetch is declared dead.
  localparam logic [7:0] TIMEOUT_LAST = 8'(FETCH_TIMEOUT - 1);

  logic [2:0] state;
  logic [2:0] state_next;
  logic [7:0] fetch_cnt;
  logic       fetch_expired;
  logic       branch_taken;

  assign fetch_expired = (fetch_cnt == TIMEOUT_LAST);
  assign branch_taken  = (state == S_WB) && (Op == OP_BRZ) && a_zero;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_next = state;
    case (state)
      S_IDLE:   if (run) state_next = S_FETCH;
      S_FETCH: begin
        if (imem_ack)           state_next = S_DECODE;
        else if (fetch_expired) state_next = S_FAULT;
      end
      S_DECODE: begin
        if (Op == OP_NOP)       state_next = S_FETCH;
        else if (Op == OP_HALT) state_next = S_HALT;
        else                    state_next = S_EXEC;
      end
      S_EXEC:   state_next = S_WB;
      S_WB:     state_next = S_FETCH;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_FAULT;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      PC        <= RESET_PC;
      fetch_cnt <= 8'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      state <= state_next;
      if (state == S_FETCH && !imem_ack) fetch_cnt <= fetch_cnt + 8'd1;
      else                               fetch_cnt <= 8'd0;
      if (state == S_FETCH && imem_ack) PC <= PC + PC_STEP;
      else if (branch_taken)            PC <= ALUOut;
    end
  end

  // EXEC controls are held through WB so the register-file write sees a stable datapath.
  always_comb begin
    imem_req    = 1'b0;
    IRWrite     = 1'b0;
    ALUOp       = 3'd0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 1'b0;
    immShift    = 2'd0;
    numBits     = 2'd0;
    writeEnable = 1'b0;
    if (state == S_FETCH) begin
      imem_req = 1'b1;
      IRWrite  = imem_ack;
    end
    if (state == S_EXEC || state == S_WB) begin
      if (!Op[3]) begin
        ALUOp = Op[2:0];
      end else if (Op[3:2] == 2'b10) begin
        ALUOp   = {1'b0, Op[1:0]};
        ALUSrcB = 1'b1;
        numBits = 2'd1;
      end else if (Op == OP_LUI) begin
        ALUSrcB  = 1'b1;
        numBits  = 2'd2;
        immShift = 2'd2;
      end else if (Op == OP_BRZ) begin
        ALUSrcA = 1'b1;
        ALUSrcB = 1'b1;
        numBits = 2'd1;
      end
    end
    if (state == S_WB) writeEnable = (Op <= OP_LUI);
  end

  assign busy   = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC) || (state == S_WB);
  assign halted = (state == S_HALT);
  assign fault  = (state == S_FAULT);

`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
  // An instruction retires when WB completes or a NOP leaves DECODE.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      retired <= 16'd0;
    end else if (state == S_WB || (state == S_DECODE && Op == OP_NOP)) begin
      retired <= retired + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: cycle-by-cycle vector table plus timeout, wrap and reset sequences.
// Define MULTICYCLE_CTRL_RETIRE_CNT_EN to also check the retired counter.
module tb_multicycle_controller;

  typedef struct packed {
    logic        req;
    logic        irw;
    logic [2:0]  alu_op;
    logic        src_a;
    logic        src_b;
    logic [1:0]  imm_shift;
    logic [1:0]  num_bits;
    logic        we;
    logic        busy;
    logic        halted;
    logic        fault;
    logic [15:0] pc;
  } outs_t;

  typedef struct {
    logic        run;
    logic        ack;
    logic [3:0]  op;
    logic        az;
    logic [15:0] alu;
    outs_t       exp;
  } vec_t;

  logic        CLK;
  logic        reset;
  logic        run;
  logic        imem_ack;
  logic [3:0]  Op;
  logic        a_zero;
  logic [15:0] ALUOut;
  logic        imem_req;
  logic [15:0] PC;
  logic        IRWrite;
  logic [2:0]  ALUOp;
  logic        ALUSrcA;
  logic        ALUSrcB;
  logic [1:0]  immShift;
  logic [1:0]  numBits;
  logic        writeEnable;
  logic        busy;
  logic        halted;
  logic        fault;
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
  logic [15:0] retired;
`endif

  int passed = 0;
  int total  = 0;
  vec_t vecs[$];

  multicycle_controller dut (
    .CLK(CLK), .reset(reset), .run(run), .imem_ack(imem_ack), .Op(Op),
    .a_zero(a_zero), .ALUOut(ALUOut), .imem_req(imem_req), .PC(PC),
    .IRWrite(IRWrite), .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .immShift(immShift), .numBits(numBits), .writeEnable(writeEnable),
    .busy(busy), .halted(halted), .fault(fault)
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
    , .retired(retired)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic outs_t sample();
    outs_t o;
    o = '{req: imem_req, irw: IRWrite, alu_op: ALUOp, src_a: ALUSrcA, src_b: ALUSrcB,
          imm_shift: immShift, num_bits: numBits, we: writeEnable, busy: busy,
          halted: halted, fault: fault, pc: PC};
    return o;
  endfunction

  function automatic outs_t o_idle(input logic [15:0] pc);
    outs_t o = '0;
    o.pc = pc;
    return o;
  endfunction

  function automatic outs_t o_fetch(input logic irw, input logic [15:0] pc);
    outs_t o = '0;
    o.req = 1'b1; o.irw = irw; o.busy = 1'b1; o.pc = pc;
    return o;
  endfunction

  function automatic outs_t o_dec(input logic [15:0] pc);
    outs_t o = '0;
    o.busy = 1'b1; o.pc = pc;
    return o;
  endfunction

  function automatic outs_t o_alu(input logic [2:0] alu_op, input logic sa, input logic sb,
                                  input logic [1:0] is, input logic [1:0] nb,
                                  input logic we, input logic [15:0] pc);
    outs_t o = '0;
    o.alu_op = alu_op; o.src_a = sa; o.src_b = sb; o.imm_shift = is; o.num_bits = nb;
    o.we = we; o.busy = 1'b1; o.pc = pc;
    return o;
  endfunction

  function automatic outs_t o_halt(input logic [15:0] pc);
    outs_t o = '0;
    o.halted = 1'b1; o.pc = pc;
    return o;
  endfunction

  function automatic outs_t o_fault(input logic [15:0] pc);
    outs_t o = '0;
    o.fault = 1'b1; o.pc = pc;
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
    else passed++;
  endtask

  task automatic add(input logic r, input logic a, input logic [3:0] op, input logic az,
                     input logic [15:0] alu, input outs_t e);
    vec_t v;
    v.run = r; v.ack = a; v.op = op; v.az = az; v.alu = alu; v.exp = e;
    vecs.push_back(v);
  endtask

  // Inputs change on the falling edge; outputs are compared 1 ns later.
  task automatic apply(input logic r, input logic a, input logic [3:0] op, input logic az,
                       input logic [15:0] alu);
    @(negedge CLK);
    run = r; imem_ack = a; Op = op; a_zero = az; ALUOut = alu;
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    reset = 1'b0; run = 1'b0; imem_ack = 1'b0; Op = 4'h0; a_zero = 1'b0; ALUOut = 16'h0;
    #1;
    check("reset_state", {1'b0, sample()}, {1'b0, o_idle(16'h0000)});
    @(negedge CLK);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; run = 1'b0; imem_ack = 1'b0; Op = 4'h0; a_zero = 1'b0; ALUOut = 16'h0;

    add(1, 0, 4'h3, 0, 16'h0000, o_idle(16'h0000));
    add(0, 1, 4'h3, 0, 16'h0000, o_fetch(1, 16'h0000));
    add(0, 0, 4'h3, 0, 16'h0000, o_dec(16'h0001));
    add(0, 0, 4'h3, 0, 16'h0000, o_alu(3'd3, 0, 0, 2'd0, 2'd0, 0, 16'h0001));
    add(0, 0, 4'h3, 0, 16'h0000, o_alu(3'd3, 0, 0, 2'd0, 2'd0, 1, 16'h0001));
    add(0, 1, 4'hD, 0, 16'h0000, o_fetch(1, 16'h0001));
    add(0, 0, 4'hD, 0, 16'h0000, o_dec(16'h0002));
    add(0, 0, 4'hD, 0, 16'h0000, o_alu(3'd0, 1, 1, 2'd0, 2'd1, 0, 16'h0002));
    add(0, 0, 4'hD, 1, 16'h0040, o_alu(3'd0, 1, 1, 2'd0, 2'd1, 0, 16'h0002));
    add(0, 1, 4'hD, 0, 16'h0000, o_fetch(1, 16'h0040));
    add(0, 0, 4'hD, 0, 16'h0000, o_dec(16'h0041));
    add(0, 0, 4'hD, 0, 16'h0000, o_alu(3'd0, 1, 1, 2'd0, 2'd1, 0, 16'h0041));
    add(0, 0, 4'hD, 0, 16'h1234, o_alu(3'd0, 1, 1, 2'd0, 2'd1, 0, 16'h0041));
    add(1, 0, 4'h9, 0, 16'h0000, o_fetch(0, 16'h0041));
    add(0, 1, 4'h9, 0, 16'h0000, o_fetch(1, 16'h0041));
    add(0, 0, 4'h9, 0, 16'h0000, o_dec(16'h0042));
    add(0, 0, 4'h9, 0, 16'h0000, o_alu(3'd1, 0, 1, 2'd0, 2'd1, 0, 16'h0042));
    add(0, 0, 4'h9, 0, 16'h0000, o_alu(3'd1, 0, 1, 2'd0, 2'd1, 1, 16'h0042));
    add(0, 1, 4'hC, 0, 16'h0000, o_fetch(1, 16'h0042));
    add(0, 0, 4'hC, 0, 16'h0000, o_dec(16'h0043));
    add(0, 0, 4'hC, 0, 16'h0000, o_alu(3'd0, 0, 1, 2'd2, 2'd2, 0, 16'h0043));
    add(0, 0, 4'hC, 0, 16'h0000, o_alu(3'd0, 0, 1, 2'd2, 2'd2, 1, 16'h0043));
    add(0, 1, 4'hE, 0, 16'h0000, o_fetch(1, 16'h0043));
    add(0, 0, 4'hE, 0, 16'h0000, o_dec(16'h0044));
    add(0, 1, 4'h7, 0, 16'h0000, o_fetch(1, 16'h0044));
    add(0, 0, 4'h7, 0, 16'h0000, o_dec(16'h0045));
    add(0, 0, 4'h7, 0, 16'h0000, o_alu(3'd7, 0, 0, 2'd0, 2'd0, 0, 16'h0045));
    add(0, 0, 4'h7, 0, 16'h0000, o_alu(3'd7, 0, 0, 2'd0, 2'd0, 1, 16'h0045));
    add(0, 1, 4'hF, 0, 16'h0000, o_fetch(1, 16'h0045));
    add(0, 0, 4'hF, 0, 16'h0000, o_dec(16'h0046));
    add(1, 0, 4'hF, 0, 16'h0000, o_halt(16'h0046));
    add(0, 1, 4'h3, 1, 16'h0099, o_halt(16'h0046));
    add(1, 0, 4'h3, 0, 16'h0000, o_halt(16'h0046));

    do_reset();
    foreach (vecs[i]) begin
      apply(vecs[i].run, vecs[i].ack, vecs[i].op, vecs[i].az, vecs[i].alu);
      check($sformatf("vec%0d", i), {1'b0, sample()}, {1'b0, vecs[i].exp});
    end
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
    check("retired_table", {16'h0, retired}, 32'd7);
`endif

    // Fetch timeout: 15 unacknowledged cycles, then FAULT absorbs ack and run.
    do_reset();
    apply(1, 0, 4'h0, 0, 16'h0);
    for (int i = 0; i < 15; i++) begin
      apply(0, 0, 4'h0, 0, 16'h0);
      check($sformatf("fetch_wait%0d", i), {1'b0, sample()}, {1'b0, o_fetch(0, 16'h0000)});
    end
    apply(0, 1, 4'h3, 0, 16'h0);
    check("fault_late_ack", {1'b0, sample()}, {1'b0, o_fault(16'h0000)});
    apply(1, 1, 4'h3, 0, 16'h0);
    check("fault_sticky", {1'b0, sample()}, {1'b0, o_fault(16'h0000)});

    // Ack on the last allowed cycle wins; taken branch to FFFF then PC wraps on fetch.
    do_reset();
    apply(1, 0, 4'h0, 0, 16'h0);
    for (int i = 0; i < 14; i++) apply(0, 0, 4'hD, 0, 16'h0);
    apply(0, 1, 4'hD, 0, 16'h0);
    check("ack_last_cycle", {1'b0, sample()}, {1'b0, o_fetch(1, 16'h0000)});
    apply(0, 0, 4'hD, 0, 16'h0);
    check("ack_wins_decode", {1'b0, sample()}, {1'b0, o_dec(16'h0001)});
    apply(0, 0, 4'hD, 0, 16'h0);
    apply(0, 0, 4'hD, 1, 16'hFFFF);
    check("brz_wb", {1'b0, sample()}, {1'b0, o_alu(3'd0, 1, 1, 2'd0, 2'd1, 0, 16'h0001)});
    apply(0, 1, 4'hE, 0, 16'h0);
    check("fetch_at_ffff", {1'b0, sample()}, {1'b0, o_fetch(1, 16'hFFFF)});
    apply(0, 0, 4'hE, 0, 16'h0);
    check("pc_wrap", {1'b0, sample()}, {1'b0, o_dec(16'h0000)});
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
    check("retired_wrap_seq", {16'h0, retired}, 32'd1);
`endif

    // Asynchronous reset in the middle of EXEC, then restart from RESET_PC.
    do_reset();
    apply(1, 0, 4'h3, 0, 16'h0);
    apply(0, 1, 4'h3, 0, 16'h0);
    apply(0, 0, 4'h3, 0, 16'h0);
    apply(0, 0, 4'h3, 0, 16'h0);
    check("exec_before_reset", {1'b0, sample()}, {1'b0, o_alu(3'd3, 0, 0, 2'd0, 2'd0, 0, 16'h0001)});
    #1 reset = 1'b0;
    #1 check("async_reset", {1'b0, sample()}, {1'b0, o_idle(16'h0000)});
    #1 reset = 1'b1;
    apply(1, 0, 4'h3, 0, 16'h0);
    check("restart_idle", {1'b0, sample()}, {1'b0, o_idle(16'h0000)});
    apply(0, 1, 4'h3, 0, 16'h0);
    check("restart_fetch", {1'b0, sample()}, {1'b0, o_fetch(1, 16'h0000)});
    apply(0, 0, 4'h3, 0, 16'h0);
    check("restart_pc", {1'b0, sample()}, {1'b0, o_dec(16'h0001)});

`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
    // Three NOPs and two ALU ops retire five instructions.
    do_reset();
    apply(1, 0, 4'h0, 0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      apply(0, 1, 4'hE, 0, 16'h0);
      apply(0, 0, 4'hE, 0, 16'h0);
    end
    for (int i = 0; i < 2; i++) begin
      apply(0, 1, 4'h3, 0, 16'h0);
      apply(0, 0, 4'h3, 0, 16'h0);
      apply(0, 0, 4'h3, 0, 16'h0);
      apply(0, 0, 4'h3, 0, 16'h0);
    end
    apply(0, 0, 4'h0, 0, 16'h0);
    check("retire_fetch", {1'b0, sample()}, {1'b0, o_fetch(0, 16'h0005)});
    check("retired_five", {16'h0, retired}, 32'd5);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
